// File: rtl/residual_pkg.sv
// Shared encodings for the residual pipeline controller: state codes,
// FSM encodings and the all-zero block classifier.
package residual_pkg;

    // Residual state codes, kept in step with the codec's defines.v
    localparam logic [3:0] Intra16x16DCLevel_s   = 4'd0;
    localparam logic [3:0] Intra16x16ACLevel_s   = 4'd1;
    localparam logic [3:0] Intra16x16ACLevel_0_s = 4'd2;
    localparam logic [3:0] LumaLevel_s           = 4'd3;
    localparam logic [3:0] LumaLevel_0_s         = 4'd4;
    localparam logic [3:0] ChromaDCLevel_Cb_s    = 4'd5;
    localparam logic [3:0] ChromaDCLevel_Cr_s    = 4'd6;
    localparam logic [3:0] ChromaACLevel_Cb_s    = 4'd7;
    localparam logic [3:0] ChromaACLevel_Cb_0_s  = 4'd8;
    localparam logic [3:0] ChromaACLevel_Cr_s    = 4'd9;
    localparam logic [3:0] ChromaACLevel_Cr_0_s  = 4'd10;

    typedef enum logic {C_IDLE, C_BUSY} cavlc_state_t;
    typedef enum logic {T_IDLE, T_BUSY} xform_state_t;

    function automatic logic is_all_zero(input logic [15:0] s);
        return (s == 16'(Intra16x16ACLevel_0_s)) ||
               (s == 16'(LumaLevel_0_s)) ||
               (s == 16'(ChromaACLevel_Cb_0_s)) ||
               (s == 16'(ChromaACLevel_Cr_0_s));
    endfunction

endpackage

// File: rtl/residual_desc_fifo.sv
// Pending-transform descriptor FIFO; DEPTH must be a power of two.
// Read data is the head entry, visible combinationally.
module residual_desc_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = ena & push & (count != CW'(DEPTH));
    assign do_pop  = ena & pop & (count != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/residual_pipe_ctrl.sv
// Residual block pipeline controller: CAVLC stage feeding a transform stage.
// Define RESIDUAL_PIPE_CTRL_PERF_EN to build the perf counters.
module residual_pipe_ctrl
    import residual_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               blk_start,
    input  logic [STATE_W-1:0] blk_state,
    output logic               blk_ready,
    output logic               cavlc_start,
    input  logic               cavlc_valid,
    output logic               transform_start,
    output logic [STATE_W-1:0] transform_state,
    input  logic               transform_valid,
    output logic               blk_done,
    output logic               idle,
    output logic [15:0]        perf_blk_cnt,
    output logic [15:0]        perf_stall_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;

    cavlc_state_t       c_state, c_next;
    xform_state_t       t_state, t_next;
    logic [STATE_W-1:0] cavlc_desc;
    logic               cv_q, tv_q;
    logic [CW-1:0]      fifo_cnt;
    logic [STATE_W-1:0] fifo_dout;
    logic [STATE_W-1:0] push_data;
    logic               accept, blk_zero, cavlc_fin, xform_fin;
    logic               push, pop;

    assign blk_zero  = is_all_zero(16'(blk_state));
    assign blk_ready = (c_state == C_IDLE) && (fifo_cnt < CW'(DEPTH));
    assign accept    = ena & blk_start & blk_ready;
    assign cavlc_fin = ena & (c_state == C_BUSY) & cavlc_valid & ~cv_q;
    assign xform_fin = ena & (t_state == T_BUSY) & transform_valid & ~tv_q;
    assign pop       = ena & (t_state == T_IDLE) & (fifo_cnt != '0);
    assign idle      = (c_state == C_IDLE) && (t_state == T_IDLE) &&
                       (fifo_cnt == '0);

    // All-zero blocks skip CAVLC and go straight into the FIFO
    always_comb begin
        c_next    = c_state;
        push      = 1'b0;
        push_data = blk_state;
        unique case (c_state)
            C_IDLE: begin
                if (accept) begin
                    if (blk_zero) push   = 1'b1;
                    else          c_next = C_BUSY;
                end
            end
            C_BUSY: begin
                if (cavlc_fin) begin
                    push      = 1'b1;
                    push_data = cavlc_desc;
                    c_next    = C_IDLE;
                end
            end
            default: c_next = C_IDLE;
        endcase
    end

    always_comb begin
        t_next = t_state;
        unique case (t_state)
            T_IDLE:  if (pop)       t_next = T_BUSY;
            T_BUSY:  if (xform_fin) t_next = T_IDLE;
            default: t_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_state         <= C_IDLE;
            t_state         <= T_IDLE;
            cv_q            <= 1'b0;
            tv_q            <= 1'b0;
            cavlc_desc      <= '0;
            cavlc_start     <= 1'b0;
            transform_start <= 1'b0;
            transform_state <= '0;
            blk_done        <= 1'b0;
        end else if (ena) begin
            c_state         <= c_next;
            t_state         <= t_next;
            cv_q            <= cavlc_valid;
            tv_q            <= transform_valid;
            cavlc_start     <= accept & ~blk_zero;
            transform_start <= pop;
            blk_done        <= xform_fin;
            if (accept) cavlc_desc      <= blk_state;
            if (pop)    transform_state <= fifo_dout;
        end
    end

    residual_desc_fifo #(
        .WIDTH(STATE_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .push (push),
        .din  (push_data),
        .pop  (pop),
        .dout (fifo_dout),
        .count(fifo_cnt)
    );

`ifdef RESIDUAL_PIPE_CTRL_PERF_EN
    logic [15:0] blk_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (ena) begin
            if (xform_fin && blk_cnt_q != 16'hFFFF)
                blk_cnt_q <= blk_cnt_q + 16'd1;
            if (blk_start && !blk_ready && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign perf_blk_cnt   = blk_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_blk_cnt   = 16'd0;
    assign perf_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_residual_pipe_ctrl.sv
// Directed bench for residual_pipe_ctrl: single, all-zero, ena hold,
// mid-flight reset and overlapped blocks with perf counters.
module tb_residual_pipe_ctrl;
    import residual_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        blk_start;
    logic [3:0]  blk_state;
    logic        blk_ready;
    logic        cavlc_start;
    logic        cavlc_valid;
    logic        transform_start;
    logic [3:0]  transform_state;
    logic        transform_valid;
    logic        blk_done;
    logic        idle;
    logic [15:0] perf_blk_cnt;
    logic [15:0] perf_stall_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    residual_pipe_ctrl #(.STATE_W(4), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .blk_start      (blk_start),
        .blk_state      (blk_state),
        .blk_ready      (blk_ready),
        .cavlc_start    (cavlc_start),
        .cavlc_valid    (cavlc_valid),
        .transform_start(transform_start),
        .transform_state(transform_state),
        .transform_valid(transform_valid),
        .blk_done       (blk_done),
        .idle           (idle),
        .perf_blk_cnt   (perf_blk_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chks(input string tag, input logic [3:0] obs,
                        input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        ena             = 1'b1;
        blk_start       = 1'b0;
        blk_state       = '0;
        cavlc_valid     = 1'b0;
        transform_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        chkb("rst_ready", blk_ready, 1'b1);
        chkb("rst_idle", idle, 1'b1);
        chkb("rst_cavlc_start", cavlc_start, 1'b0);
        chkb("rst_xform_start", transform_start, 1'b0);
        chkb("rst_done", blk_done, 1'b0);
        chks("rst_xform_state", transform_state, 4'd0);
        chkw("rst_perf_blk", perf_blk_cnt, 16'd0);
        chkw("rst_perf_stall", perf_stall_cnt, 16'd0);

        // Non-zero block, cycle t
        tick();
        blk_state = LumaLevel_s;
        blk_start = 1'b1;
        chkb("t1_ready", blk_ready, 1'b1);
        tick();
        blk_start = 1'b0;
        chkb("t1_cavlc_start", cavlc_start, 1'b1);
        chkb("t1_busy_ready", blk_ready, 1'b0);
        chkb("t1_not_idle", idle, 1'b0);
        tick();
        chkb("t1_cavlc_pulse_end", cavlc_start, 1'b0);
        repeat (3) tick();
        cavlc_valid = 1'b1;
        tick();
        chkb("t1_xs_early", transform_start, 1'b0);
        chkb("t1_ready_again", blk_ready, 1'b1);
        tick();
        chkb("t1_xs", transform_start, 1'b1);
        chks("t1_xstate", transform_state, LumaLevel_s);
        repeat (3) tick();
        transform_valid = 1'b1;
        chkb("t1_done_early", blk_done, 1'b0);
        tick();
        chkb("t1_done", blk_done, 1'b1);
        chkb("t1_idle", idle, 1'b1);
        tick();
        chkb("t1_done_pulse_end", blk_done, 1'b0);
        cavlc_valid     = 1'b0;
        transform_valid = 1'b0;

        // All-zero block
        tick();
        blk_state = LumaLevel_0_s;
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        chkb("t2_no_cavlc", cavlc_start, 1'b0);
        chkb("t2_xs_early", transform_start, 1'b0);
        tick();
        chkb("t2_xs", transform_start, 1'b1);
        chks("t2_xstate", transform_state, LumaLevel_0_s);
        chkb("t2_no_cavlc2", cavlc_start, 1'b0);
        tick();
        transform_valid = 1'b1;
        tick();
        chkb("t2_done", blk_done, 1'b1);
        transform_valid = 1'b0;
        tick();
        chkb("t2_idle", idle, 1'b1);

        // Clock enable hold while cavlc_valid rises
        tick();
        blk_state = LumaLevel_s;
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        chkb("t3_cavlc_start", cavlc_start, 1'b1);
        tick();
        ena         = 1'b0;
        cavlc_valid = 1'b1;
        repeat (3) tick();
        chkb("t3_hold_busy", blk_ready, 1'b0);
        chkb("t3_hold_no_xs", transform_start, 1'b0);
        tick();
        ena = 1'b1;
        chkb("t3_still_busy", blk_ready, 1'b0);
        tick();
        chkb("t3_fin_ready", blk_ready, 1'b1);
        tick();
        chkb("t3_xs", transform_start, 1'b1);
        tick();
        transform_valid = 1'b1;
        tick();
        chkb("t3_done", blk_done, 1'b1);
        tick();
        chkb("t3_once_xs", transform_start, 1'b0);
        chkb("t3_once_cs", cavlc_start, 1'b0);
        chkb("t3_idle", idle, 1'b1);
        cavlc_valid     = 1'b0;
        transform_valid = 1'b0;

        // Reset with transform busy and one descriptor queued
        tick();
        blk_state = LumaLevel_0_s;
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        tick();
        chkb("t4_xs", transform_start, 1'b1);
        blk_state = ChromaACLevel_Cb_0_s;
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        chkb("t4_busy_not_idle", idle, 1'b0);
        rst_n = 1'b0;
        #1;
        chkb("t4_rst_idle", idle, 1'b1);
        chkb("t4_rst_ready", blk_ready, 1'b1);
        repeat (2) tick();
        rst_n           = 1'b1;
        transform_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chkb("t4_no_done", blk_done, 1'b0);
            chkb("t4_no_xs", transform_start, 1'b0);
            chkb("t4_idle_after", idle, 1'b1);
        end
        transform_valid = 1'b0;
        tick();

        // Overlap: three non-zero blocks, first transform held 20 cycles
        blk_state = LumaLevel_s;
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        tick();
        cavlc_valid = 1'b1;
        tick();
        cavlc_valid = 1'b0;
        chkb("t5_ready_b", blk_ready, 1'b1);
        blk_state = ChromaACLevel_Cb_s;
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        chkb("t5_xs_a", transform_start, 1'b1);
        chkb("t5_overlap_cs_b", cavlc_start, 1'b1);
        chks("t5_xstate_a", transform_state, LumaLevel_s);
        tick();
        cavlc_valid = 1'b1;
        tick();
        cavlc_valid = 1'b0;
        chkb("t5_ready_c", blk_ready, 1'b1);
        blk_state = ChromaACLevel_Cr_s;
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        chkb("t5_cs_c", cavlc_start, 1'b1);
        tick();
        cavlc_valid = 1'b1;
        tick();
        cavlc_valid = 1'b0;
        chkb("t5_full_not_ready", blk_ready, 1'b0);
        blk_state = LumaLevel_s;
        blk_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chkb("t5_refused_cs", cavlc_start, 1'b0);
        end
        tick();
        blk_start = 1'b0;
        chkb("t5_still_full", blk_ready, 1'b0);
        repeat (10) tick();
        transform_valid = 1'b1;
        tick();
        transform_valid = 1'b0;
        chkb("t5_done_a", blk_done, 1'b1);
        chks("t5_done_a_state", transform_state, LumaLevel_s);
        tick();
        chkb("t5_xs_b", transform_start, 1'b1);
        chks("t5_xstate_b", transform_state, ChromaACLevel_Cb_s);
        chkb("t5_ready_after_pop", blk_ready, 1'b1);
        tick();
        transform_valid = 1'b1;
        tick();
        transform_valid = 1'b0;
        chkb("t5_done_b", blk_done, 1'b1);
        chks("t5_done_b_state", transform_state, ChromaACLevel_Cb_s);
        tick();
        chkb("t5_xs_c", transform_start, 1'b1);
        chks("t5_xstate_c", transform_state, ChromaACLevel_Cr_s);
        tick();
        transform_valid = 1'b1;
        tick();
        transform_valid = 1'b0;
        chkb("t5_done_c", blk_done, 1'b1);
        chks("t5_done_c_state", transform_state, ChromaACLevel_Cr_s);
        chkb("t5_idle", idle, 1'b1);
        tick();
`ifdef RESIDUAL_PIPE_CTRL_PERF_EN
        chkw("perf_blk", perf_blk_cnt, 16'd3);
        chkw("perf_stall", perf_stall_cnt, 16'd5);
`else
        chkw("perf_blk", perf_blk_cnt, 16'd0);
        chkw("perf_stall", perf_stall_cnt, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
